// File: rtl/des_ctrl_pkg.sv
// Shared types for the DES block-mode sequencer.
// FSM encoding, chaining-mode constants and default core timeout.
package des_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_t;

  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CBC = 1'b1;

  localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/des_cbc_xor.sv
// CBC pre-XOR (encrypt, toward core) and post-XOR (decrypt, from core),
// plus the chaining value the next block of the message must use.
module des_cbc_xor
  import des_ctrl_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              mode,
  input  logic              enc,
  input  logic [DATA_W-1:0] blk,
  input  logic [DATA_W-1:0] chain,
  input  logic [DATA_W-1:0] core_out,
  output logic [DATA_W-1:0] pre,
  output logic [DATA_W-1:0] post,
  output logic [DATA_W-1:0] nxt_chain
);

  logic cbc;

  assign cbc       = (mode == MODE_CBC);
  assign pre       = (cbc && enc) ? (blk ^ chain) : blk;
  assign post      = (cbc && !enc) ? (core_out ^ chain) : core_out;
  assign nxt_chain = enc ? core_out : blk;

endmodule

// File: rtl/des_mode_ctrl.sv
// ECB/CBC block sequencer in front of the DES core: issues one block,
// waits for the core result (with timeout) and hands it downstream.
module des_mode_ctrl
  import des_ctrl_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int KEY_W   = 64,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_mode,
  input  logic              cfg_encrypt,
  input  logic [KEY_W-1:0]  cfg_key,
  input  logic [DATA_W-1:0] cfg_iv,
  input  logic              cfg_iv_load,
  input  logic              err_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              core_enable,
  output logic              core_encryption_enable,
  output logic [KEY_W-1:0]  core_cipher_key,
  output logic [DATA_W-1:0] core_in_data,
  input  logic              core_data_valid,
  input  logic [DATA_W-1:0] core_out_data,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CW = $clog2(TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic              mode_q;
  logic              last_q;
  logic              msg_active;
  logic [DATA_W-1:0] blk_q;
  logic [DATA_W-1:0] chain_q;
  logic [DATA_W-1:0] iv_q;

  logic              accept;
  logic              done;
  logic              tmo;
  logic              hs;
  logic              eom;
  logic              eff_mode;
  logic              eff_enc;
  logic [DATA_W-1:0] xin;
  logic [DATA_W-1:0] pre;
  logic [DATA_W-1:0] post;
  logic [DATA_W-1:0] nxt_chain;

  assign accept = in_valid && in_ready;
  assign done   = (state == WAIT) && core_data_valid;
  assign tmo    = (state == WAIT) && !core_data_valid
               && (cnt == CW'(TIMEOUT - 1));
  assign hs     = (state == OUT) && out_ready;
  assign eom    = (hs && last_q) || tmo;

  // First block of a message uses live config; later ones the latched copy.
  assign eff_mode = msg_active ? mode_q : cfg_mode;
  assign eff_enc  = msg_active ? core_encryption_enable : cfg_encrypt;
  assign xin      = (state == IDLE) ? in_data : blk_q;

  des_cbc_xor #(
    .DATA_W(DATA_W)
  ) u_xor (
    .mode      (eff_mode),
    .enc       (eff_enc),
    .blk       (xin),
    .chain     (chain_q),
    .core_out  (core_out_data),
    .pre       (pre),
    .post      (post),
    .nxt_chain (nxt_chain)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (done)     state_nxt = OUT;
        else if (tmo) state_nxt = IDLE;
      end
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    core_enable = 1'b0;
    out_valid   = 1'b0;
    unique case (state)
      IDLE:    in_ready    = rst;
      ISSUE:   core_enable = 1'b1;
      OUT:     out_valid   = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE) || msg_active;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt                    <= '0;
      mode_q                 <= MODE_ECB;
      last_q                 <= 1'b0;
      msg_active             <= 1'b0;
      blk_q                  <= '0;
      chain_q                <= '0;
      iv_q                   <= '0;
      out_data               <= '0;
      out_last               <= 1'b0;
      core_encryption_enable <= 1'b0;
      core_cipher_key        <= '0;
      core_in_data           <= '0;
      timeout_err            <= 1'b0;
    end else begin
      if (accept) begin
        blk_q        <= in_data;
        last_q       <= in_last;
        core_in_data <= pre;
        if (!msg_active) begin
          mode_q                 <= cfg_mode;
          core_encryption_enable <= cfg_encrypt;
          core_cipher_key        <= cfg_key;
          msg_active             <= 1'b1;
        end
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      if (done) begin
        out_data <= post;
        out_last <= last_q;
      end
      if (eom) msg_active <= 1'b0;
      if (cfg_iv_load) iv_q <= cfg_iv;
      // End-of-message reload takes a coinciding IV load directly.
      if (eom)
        chain_q <= cfg_iv_load ? cfg_iv : iv_q;
      else if (done && mode_q == MODE_CBC)
        chain_q <= nxt_chain;
      else if (cfg_iv_load && !msg_active)
        chain_q <= cfg_iv;
      if (tmo)          timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_des_mode_ctrl.sv
// Directed bench for des_mode_ctrl with a behavioural stub DES core.
// Stub maps the known DES vector, else XORs a constant, or stays silent.
module tb_des_mode_ctrl;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] SX  = 64'hF0F0F0F0F0F0F0F0;
  localparam logic [63:0] IV2 = 64'h123456789ABCDEF0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_mode = 1'b0;
  logic        cfg_encrypt = 1'b0;
  logic [63:0] cfg_key = '0;
  logic [63:0] cfg_iv = '0;
  logic        cfg_iv_load = 1'b0;
  logic        err_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        out_last;
  logic        core_enable;
  logic        core_encryption_enable;
  logic [63:0] core_cipher_key;
  logic [63:0] core_in_data;
  logic        core_data_valid;
  logic [63:0] core_out_data;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;
  int lat = 3;
  int stub_mode = 0;
  bit stub_pend = 1'b0;
  int stub_cnt = 0;
  int n_ov;

  always #5 clk = ~clk;

  des_mode_ctrl #(
    .DATA_W(64),
    .KEY_W(64),
    .TIMEOUT(64)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .cfg_mode               (cfg_mode),
    .cfg_encrypt            (cfg_encrypt),
    .cfg_key                (cfg_key),
    .cfg_iv                 (cfg_iv),
    .cfg_iv_load            (cfg_iv_load),
    .err_clr                (err_clr),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .in_data                (in_data),
    .in_last                (in_last),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .out_data               (out_data),
    .out_last               (out_last),
    .core_enable            (core_enable),
    .core_encryption_enable (core_encryption_enable),
    .core_cipher_key        (core_cipher_key),
    .core_in_data           (core_in_data),
    .core_data_valid        (core_data_valid),
    .core_out_data          (core_out_data),
    .busy                   (busy),
    .timeout_err            (timeout_err)
  );

  always @(posedge clk) begin
    if (core_enable && stub_mode != 2) begin
      stub_pend <= 1'b1;
      stub_cnt  <= lat;
    end else if (stub_pend) begin
      if (stub_cnt == 1) stub_pend <= 1'b0;
      stub_cnt <= stub_cnt - 1;
    end
  end

  assign core_data_valid = stub_pend && (stub_cnt == 1);

  always_comb begin
    if (stub_mode == 1)
      core_out_data = 64'hAAAAAAAAAAAAAAAA;
    else if (core_in_data == PT && core_cipher_key == KEY)
      core_out_data = CT;
    else
      core_out_data = core_in_data ^ SX;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chkb("accept_wait", n < 100, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic [63:0] ed,
                          input logic el);
    int n;
    int en;
    n  = 0;
    en = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
      if (core_enable) en++;
    end
    chkb({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, ed);
    chkb({tag, "_last"}, out_last, el);
    chkb({tag, "_one_pulse"}, en == 0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chkb("rst_in_ready", in_ready, 1'b0);
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_core_en", core_enable, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_terr", timeout_err, 1'b0);
    chk("rst_core_in", core_in_data, 64'h0);
    chk("rst_out_data", out_data, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    chkb("rel_in_ready", in_ready, 1'b1);

    cfg_mode = 1'b0;
    cfg_encrypt = 1'b1;
    cfg_key = KEY;
    send(PT, 1'b1);
    @(negedge clk);
    chkb("ecb_en", core_enable, 1'b1);
    chk("ecb_core_in", core_in_data, PT);
    chk("ecb_key", core_cipher_key, KEY);
    chkb("ecb_dir", core_encryption_enable, 1'b1);
    @(negedge clk);
    chkb("ecb_en_pulse", core_enable, 1'b0);
    wait_out("ecb", CT, 1'b1);
    @(negedge clk);
    chkb("ecb_busy", busy, 1'b0);
    chkb("ecb_ready", in_ready, 1'b1);

    cfg_iv = 64'h0;
    cfg_iv_load = 1'b1;
    @(negedge clk);
    cfg_iv_load = 1'b0;
    cfg_mode = 1'b1;
    send(PT, 1'b0);
    @(negedge clk);
    chk("cbc1_core_in", core_in_data, PT);
    wait_out("cbc1", CT, 1'b0);
    @(negedge clk);
    chkb("cbc_mid_busy", busy, 1'b1);
    cfg_mode = 1'b0;
    cfg_encrypt = 1'b0;
    cfg_key = 64'h0;
    send(PT, 1'b1);
    @(negedge clk);
    chk("cbc2_core_in", core_in_data, 64'h84CB563386A179EA);
    chk("cbc2_key", core_cipher_key, KEY);
    chkb("cbc2_dir", core_encryption_enable, 1'b1);
    wait_out("cbc2", 64'h84CB563386A179EA ^ SX, 1'b1);
    @(negedge clk);
    cfg_mode = 1'b1;
    cfg_encrypt = 1'b1;
    cfg_key = KEY;
    send(PT, 1'b1);
    @(negedge clk);
    chk("cbc_reiv_core_in", core_in_data, PT);
    wait_out("cbc3", CT, 1'b1);
    @(negedge clk);

    stub_mode = 1;
    cfg_iv = 64'hFFFFFFFFFFFFFFFF;
    cfg_iv_load = 1'b1;
    @(negedge clk);
    cfg_iv_load = 1'b0;
    cfg_encrypt = 1'b0;
    send(64'h1111111111111111, 1'b0);
    @(negedge clk);
    chk("dec1_core_in", core_in_data, 64'h1111111111111111);
    chkb("dec1_dir", core_encryption_enable, 1'b0);
    wait_out("dec1", 64'h5555555555555555, 1'b0);
    @(negedge clk);
    send(64'h2222222222222222, 1'b1);
    @(negedge clk);
    chk("dec2_core_in", core_in_data, 64'h2222222222222222);
    wait_out("dec2", 64'hBBBBBBBBBBBBBBBB, 1'b1);
    @(negedge clk);
    stub_mode = 0;

    cfg_mode = 1'b0;
    cfg_encrypt = 1'b1;
    out_ready = 1'b0;
    send(PT, 1'b1);
    @(negedge clk);
    wait_out("bp", CT, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chkb("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, CT);
      chkb("bp_in_ready", in_ready, 1'b0);
      chkb("bp_core_en", core_enable, 1'b0);
    end
    @(negedge clk);
    chkb("bp_valid6", out_valid, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    chkb("bp_done", out_valid, 1'b0);
    chkb("bp_ready", in_ready, 1'b1);

    stub_mode = 2;
    send(PT, 1'b1);
    @(negedge clk);
    chkb("tmo_issue", core_enable, 1'b1);
    n_ov = 0;
    repeat (63) begin
      @(negedge clk);
      if (out_valid) n_ov++;
    end
    @(negedge clk);
    chkb("tmo_pre_err", timeout_err, 1'b0);
    chkb("tmo_pre_ready", in_ready, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chkb("tmo_set_wins", timeout_err, 1'b1);
    chkb("tmo_ready", in_ready, 1'b1);
    chkb("tmo_busy", busy, 1'b0);
    chkb("tmo_no_out", (n_ov == 0) && !out_valid, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chkb("tmo_clr", timeout_err, 1'b0);
    stub_mode = 0;

    lat = 10;
    send(PT, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chkb("rstw_busy", busy, 1'b0);
    chkb("rstw_in_ready", in_ready, 1'b0);
    chkb("rstw_out_valid", out_valid, 1'b0);
    chk("rstw_core_in", core_in_data, 64'h0);
    chk("rstw_key", core_cipher_key, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n_ov = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) n_ov++;
    end
    chkb("rstw_late_ignored", n_ov == 0, 1'b1);
    chkb("rstw_ready", in_ready, 1'b1);
    lat = 3;

    cfg_mode = 1'b1;
    cfg_encrypt = 1'b1;
    cfg_key = KEY;
    out_ready = 1'b0;
    send(PT, 1'b1);
    @(negedge clk);
    chk("ivl_core_in", core_in_data, PT);
    wait_out("ivl", CT, 1'b1);
    cfg_iv = IV2;
    cfg_iv_load = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    cfg_iv_load = 1'b0;
    chkb("ivl_done", out_valid, 1'b0);
    send(PT, 1'b1);
    @(negedge clk);
    chk("ivl_chain", core_in_data, PT ^ IV2);
    wait_out("ivl2", (PT ^ IV2) ^ SX, 1'b1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_mode_ctrl.md
Name: des_mode_ctrl

Overview:
Block-mode sequencer in front of the DES datapath. It accepts 64-bit blocks over a valid/ready stream and issues each block to the DES core with key and direction. It waits for the core's data_valid and returns results downstream with ready/valid backpressure. Supports ECB and CBC: it holds the IV/chaining register and applies the CBC XOR on the way in (encrypt) or out (decrypt).

Parameters:
DATA_W, 64, block width
KEY_W, 64, cipher key width
TIMEOUT, 64, max cycles in WAIT for core_data_valid before abort (>=2)

Ports:
clk  in  1  block clock
rst  in  1  asynchronous active-low reset
cfg_mode  in  1  0=ECB, 1=CBC; sampled on first block of a message
cfg_encrypt  in  1  1=encrypt, 0=decrypt; sampled with cfg_mode
cfg_key  in  KEY_W  cipher key; sampled with cfg_mode
cfg_iv  in  DATA_W  IV value
cfg_iv_load  in  1  pulse: load cfg_iv into iv_reg
err_clr  in  1  pulse: clear timeout_err
in_valid  in  1  input block valid
in_ready  out  1  block accepted when in_valid&&in_ready
in_data  in  DATA_W  input block
in_last  in  1  last block of message
out_valid  out  1  result valid
out_ready  in  1  downstream ready
out_data  out  DATA_W  result block
out_last  out  1  echo of in_last for this block
core_enable  out  1  one-cycle start pulse to core
core_encryption_enable  out  1  direction to core
core_cipher_key  out  KEY_W  key to core
core_in_data  out  DATA_W  block to core
core_data_valid  in  1  core result valid
core_out_data  in  DATA_W  core result
busy  out  1  state != IDLE or msg_active
timeout_err  out  1  sticky core timeout flag

Behaviour:
- Reset: state=IDLE; all outputs 0, except in_ready=1 after reset release. iv_reg=0, chain_reg=0, msg_active=0, counter=0.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - in_ready=1.
  - On accept, latch in_data to blk_reg and in_last to last_reg.
  - If msg_active=0, latch cfg_mode/cfg_encrypt/cfg_key into mode/enc/key regs and set msg_active=1.
  - Go to ISSUE.
- ISSUE (1 cycle):
  - core_enable=1.
  - core_in_data = (CBC && enc) ? blk_reg^chain_reg : blk_reg.
  - Go to WAIT with counter=0.
- Core drive stability: core_in_data, core_cipher_key and core_encryption_enable are registered. They hold stable from ISSUE until the next ISSUE. core_enable is 0 outside ISSUE.
- WAIT:
  - Counter increments each cycle.
  - On core_data_valid, capture out_data and go to OUT:
    - ECB: out_data = core_out_data.
    - CBC encrypt: out_data = core_out_data; chain_reg <= core_out_data.
    - CBC decrypt: out_data = core_out_data^chain_reg; chain_reg <= blk_reg.
  - If counter reaches TIMEOUT-1 without core_data_valid:
    - timeout_err <= 1 and the block is dropped.
    - msg_active <= 0; chain_reg <= iv_reg.
    - Go to IDLE.
  - A core_data_valid on the timeout cycle wins over the timeout.
- OUT:
  - out_valid=1. out_data and out_last are held stable until out_valid&&out_ready, then go to IDLE.
  - If last_reg=1: msg_active <= 0 and chain_reg <= iv_reg.
- core_data_valid outside WAIT is ignored.
- Latency: in accept to out_valid = 2 + core latency cycles. Throughput is one block per (3 + core latency) cycles with out_ready held high; no input overlap.
- cfg_iv_load:
  - Always writes iv_reg.
  - Also writes chain_reg when msg_active=0 and no end-of-message reload happens that cycle.
  - If it coincides with the last-block OUT handshake or a timeout, chain_reg takes the new cfg_iv.
  - Mid-message it affects only the next message.
- err_clr clears timeout_err. If err_clr and a timeout occur in the same cycle, set wins.
- Config changes while msg_active=1 are ignored until the message ends.
- Reset mid-operation returns immediately to the reset state. A core_data_valid arriving after reset is ignored.

Decomposition:
- Package des_ctrl_pkg: state enum (IDLE, ISSUE, WAIT, OUT), mode constants MODE_ECB/MODE_CBC, default TIMEOUT.
- One sub-module, des_cbc_xor: combinational pre/post XOR select, from mode, enc, blk, chain and core_out.
- FSM, chain/IV registers and timeout counter stay in des_mode_ctrl.

Test Plan:
- ECB encrypt with the real DES core: key 133457799BBCDFF1, in_data 0123456789ABCDEF, in_last=1 -> out_data 85E813540F0AB405, out_last=1, core_enable is a single-cycle pulse.
- CBC encrypt, IV=0, two blocks of 0123456789ABCDEF -> block 1 out = 85E813540F0AB405; block 2 core_in_data = 84CB563386A179EA; after out_last, chain_reg == 0.
- CBC decrypt with a stub core returning AAAAAAAAAAAAAAAA, IV=FFFFFFFFFFFFFFFF, inputs 1111111111111111 then 2222222222222222 -> out 5555555555555555 then BBBBBBBBBBBBBBBB.
- Backpressure: out_ready low 5 cycles during OUT -> out_valid stays 1 with out_data stable, in_ready=0, no second core_enable; handshake on the 6th cycle.
- Timeout: stub core never asserts valid, TIMEOUT=64 -> timeout_err=1 at cycle 64 of WAIT, no out_valid, in_ready=1 next cycle; err_clr clears it.
- Reset during WAIT -> all outputs 0, busy=0; a late core_data_valid produces no out_valid; cfg_iv_load coinciding with the last OUT handshake puts the new IV into chain_reg.
